// File: rtl/byte_packer_8b_to_32b.sv
// byte_packer_8b_to_32b: reassembles a big-endian byte stream into 32-bit words buffered in a show-ahead FIFO
// Ports: clk_4f/reset_L clock and async active-low reset; data_in/valid_in byte stream in;
// pop consumer read strobe; data_out/valid_out FIFO head; fifo_full occupancy flag;
// overflow sticky dropped-word flag; align_err one-cycle broken-group pulse.
module byte_packer_8b_to_32b #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk_4f,
  input  logic        reset_L,
  input  logic [7:0]  data_in,
  input  logic        valid_in,
  input  logic        pop,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        fifo_full,
  output logic        overflow,
  output logic        align_err
);
  logic [1:0]       lane_q, lane_d;
  logic [7:0]       b0_q, b1_q, b2_q;
  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, align_err_q;
  logic             full, push, do_pop, wr_en;
  logic [31:0]      word;
  assign full      = count_q == (PTR_W+1)'(DEPTH);
  assign valid_out = count_q != '0;
  assign fifo_full = full;
  assign do_pop    = pop && valid_out;
  assign push      = valid_in && lane_q == 2'd3;
  // a pop on the same edge frees the slot, so a full FIFO still accepts the word
  assign wr_en     = push && (!full || do_pop);
  // last byte bypasses the lane registers straight into the word
  assign word      = {b0_q, b1_q, b2_q, data_in};
  assign count_d   = count_q + (PTR_W+1)'(wr_en) - (PTR_W+1)'(do_pop);
  // a gap in valid_in mid-group abandons the partial group
  assign lane_d    = valid_in ? lane_q + 2'd1 : 2'd0;
  assign data_out  = valid_out ? mem[rd_ptr_q] : '0;
  assign overflow  = overflow_q;
  assign align_err = align_err_q;
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      lane_q      <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      b2_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      lane_q      <= lane_d;
      if (valid_in && lane_q == 2'd0) b0_q <= data_in;
      if (valid_in && lane_q == 2'd1) b1_q <= data_in;
      if (valid_in && lane_q == 2'd2) b2_q <= data_in;
      wr_ptr_q    <= wr_ptr_q + PTR_W'(wr_en);
      rd_ptr_q    <= rd_ptr_q + PTR_W'(do_pop);
      count_q     <= count_d;
      overflow_q  <= overflow_q | (push && full && !do_pop);
      align_err_q <= !valid_in && lane_q != 2'd0;
    end
  end
  always_ff @(posedge clk_4f) begin
    if (wr_en) mem[wr_ptr_q] <= word;
  end
endmodule
